ahb3lite_n: RTL and testbench
=============================

# ahb3lite_n

Zero-wait-state AHB3-Lite slave that fronts an on-chip word-addressed memory of MEM_DEPTH words. It sits on the AHB3-Lite bus behind the decoder, which drives HSEL. Byte, halfword and word reads and writes are supported; illegal transfers receive the standard two-cycle ERROR response. In the system, HREADY is tied to this block's HREADYOUT when it is the only slave.

## Interface
- MEM_SIZE, 32: width of a memory word in bits; must equal HDATA_SIZE.
- MEM_DEPTH, 256: number of memory words; power of two.
- HADDR_SIZE, 32: address bus width.
- HDATA_SIZE, 32: data bus width.
- Clocking: one clock; reset is asynchronous and active-low.
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  HADDR_SIZE  byte address, address phase.
- HWDATA  in  HDATA_SIZE  write data, data phase.
- HRDATA  out  HDATA_SIZE  read data, data phase.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size: 0 = byte, 1 = halfword, 2 = word.
- HBURST  in  3  burst type; accepted but ignored.
- HPROT  in  4  protection; accepted but ignored.
- HTRANS  in  2  transfer type: 0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HREADY  in  1  bus ready; an address phase is sampled only when it is 1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Accept condition, evaluated at the rising edge: HSEL & HREADY & HTRANS[1]. IDLE, BUSY or unselected cycles cause no access and an OKAY response.
- On accept, register HADDR, HWRITE and HSIZE for the data phase.
- Word index is HADDR[log2(MEM_DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
- A transfer is illegal if HSIZE > 2 or it is misaligned:
  - halfword with HADDR[0] = 1;
  - word with HADDR[1:0] ≠ 0.
- Write data phase:
  - HWDATA is written at the end of the data phase, on the edge where HREADYOUT = 1.
  - Only the addressed byte lanes are written: byte → lane HADDR[1:0]; halfword → lanes {HADDR[1],0} and {HADDR[1],1}; word → all four lanes. Lane n is bits 8n+7:8n (little-endian).
  - Unaddressed lanes keep their old value.
- Read data phase:
  - HRDATA shows the full memory word at the registered index, combinationally, from the first data-phase cycle.
  - The master selects the lanes it needs.
  - Outside a read data phase, HRDATA = 0.
- Back-to-back transfers: a read whose data phase follows a write data phase to the same word returns the newly written data, including the merged byte lanes.
- Illegal transfer: no memory access, then the two-cycle ERROR response.
  - Cycle 1: HREADYOUT = 0, HRESP = 1.
  - Cycle 2: HREADYOUT = 1, HRESP = 1.
  - Then return to OKAY.
- Response state machine:
  - OKAY (HREADYOUT = 1, HRESP = 0): an illegal accept moves to ERR1; a legal accept stays in OKAY.
  - ERR1 (HREADYOUT = 0, HRESP = 1): always moves to ERR2.
  - ERR2 (HREADYOUT = 1, HRESP = 1): a new legal or idle transfer may be sampled in this cycle and moves to OKAY; an illegal accept moves to ERR1.
- Memory contents are not initialised by reset; reads of unwritten words are undefined.

## Timing
- Reset values: HREADYOUT = 1, HRESP = 0, HRDATA = 0, state OKAY, no pending data phase.
- Asserting HRESETn low mid-transfer discards any pending write and aborts an ERROR sequence immediately.
- OKAY transfers have zero wait states: address phase in cycle N, data phase in cycle N+1 with HREADYOUT = 1.
- Pipelined bursts complete one transfer per cycle.
- The ERROR sequence inserts exactly one wait state.
- The write commit and the next address-phase sample happen on the same edge.

## Test plan
- Reset: hold HRESETn low for 20 ns → HREADYOUT = 1, HRESP = 0, HRDATA = 0. After release, IDLE cycles keep OKAY.
- Word write then read: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → HRDATA = 0xDEADBEEF in the read data phase, zero wait states.
- Byte lanes:
  - word-write 0x11223344 to 0x20;
  - byte-write 0xAA to 0x21;
  - halfword-write 0xBBCC to 0x22;
  - read 0x20 → 0xBBCCAA44.
- Address wrap: write 0x5A5A5A5A to 0x400 with MEM_DEPTH = 256 → a read of 0x000 returns 0x5A5A5A5A.
- Errors: word access at 0x02, or HSIZE = 3 → one cycle HREADYOUT = 0 / HRESP = 1, then one cycle HREADYOUT = 1 / HRESP = 1. Memory is unchanged, verified by reading the word.
- Pipelined burst: INCR4 word writes to 0x40..0x4C, then an INCR4 read → data returned in consecutive cycles, HTRANS = BUSY inserted mid-burst is ignored, all responses OKAY.

Source files
------------

// File: rtl/ahb3lite_n.sv
// Zero-wait-state AHB3-Lite slave over a byte-lane-writable word memory.
// Illegal sizes/alignments get the two-cycle ERROR response and no memory access.
module ahb3lite_n #(
  parameter int MEM_SIZE   = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int AW        = $clog2(MEM_DEPTH);
  localparam int NUM_LANES = HDATA_SIZE / 8;

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

  typedef struct packed {
    logic          vld;
    logic          write;
    logic [2:0]    size;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
  } dphase_t;

  state_t                 r_state, w_next;
  dphase_t                r_dp;
  logic [MEM_SIZE-1:0]    r_mem [MEM_DEPTH];
  logic                   w_accept, w_illegal, w_we;
  logic [NUM_LANES-1:0]   w_be;
  logic                   w_unused;

  assign w_unused  = ^{HBURST, HPROT, HADDR[HADDR_SIZE-1:AW+2]};
  assign w_accept  = HSEL & HREADY & HTRANS[1];
  assign w_illegal = (HSIZE > 3'd2) | ((HSIZE == 3'd1) & HADDR[0]) |
                     ((HSIZE == 3'd2) & (|HADDR[1:0]));

  // Only legal accepts open a data phase; illegal ones go straight to ERROR.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp <= '0;
    end else if (HREADY) begin
      r_dp.vld   <= w_accept & ~w_illegal;
      r_dp.write <= HWRITE;
      r_dp.size  <= HSIZE;
      r_dp.lane  <= HADDR[1:0];
      r_dp.idx   <= HADDR[AW+1:2];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_OKAY;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (r_state)
      ST_OKAY: if (w_accept & w_illegal) w_next = ST_ERR1;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        w_next    = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP  = 1'b1;
        w_next = (w_accept & w_illegal) ? ST_ERR1 : ST_OKAY;
      end
      default: w_next = ST_OKAY;
    endcase
  end

  always_comb begin
    w_be = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      w_be[n] = (r_dp.size == 3'd2) |
                ((r_dp.size == 3'd1) & (r_dp.lane[1] == 1'(n >> 1))) |
                ((r_dp.size == 3'd0) & (r_dp.lane == 2'(n)));
    end
  end

  assign w_we = r_dp.vld & r_dp.write & HREADYOUT;

  // Memory is deliberately not reset; the commit edge also samples the next address.
  always_ff @(posedge HCLK) begin
    if (w_we) begin
      for (int n = 0; n < NUM_LANES; n++)
        if (w_be[n]) r_mem[r_dp.idx][8*n +: 8] <= HWDATA[8*n +: 8];
    end
  end

  assign HRDATA = (r_dp.vld & ~r_dp.write) ? r_mem[r_dp.idx] : '0;

endmodule

// File: tb/tb_ahb3lite_n.sv
// Bench for ahb3lite_n: per-cycle bus driver with a byte-array memory model.
module tb_ahb3lite_n;
  localparam int DEPTH  = 256;
  localparam int NBYTES = DEPTH * 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY, HREADYOUT, HRESP;

  assign HREADY = HREADYOUT;

  ahb3lite_n #(.MEM_SIZE(32), .MEM_DEPTH(DEPTH), .HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0, failures = 0;
  logic [7:0]  mb [NBYTES];
  logic        p_val, p_ill, p_w;
  logic [31:0] p_a, p_wd, last_rd;
  logic [2:0]  p_sz;

  function automatic logic illegal(logic [31:0] a, logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] model_word(logic [31:0] a);
    int b;
    b = int'(a % NBYTES) & ~3;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  // Checks the data phase now in progress, then presents the next address phase.
  task automatic cyc(input string nm, input logic sel, input logic [1:0] tr,
                     input logic [31:0] a, input logic w, input logic [2:0] sz,
                     input logic [31:0] wd);
    logic [31:0] exp_rd;
    int ba;
    if (p_val && p_ill) begin
      checks++;
      if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin
        failures++;
        $display("FAIL %s err1: ready=%b resp=%b rdata=%h, want ready=0 resp=1 rdata=0",
                 nm, HREADYOUT, HRESP, HRDATA);
      end
      HSEL = 1'b0; HTRANS = 2'b00;
      @(posedge HCLK); #1;
      checks++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin
        failures++;
        $display("FAIL %s err2: ready=%b resp=%b rdata=%h, want ready=1 resp=1 rdata=0",
                 nm, HREADYOUT, HRESP, HRDATA);
      end
    end else begin
      exp_rd = (p_val && !p_w) ? model_word(p_a) : 32'h0;
      checks++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== exp_rd) begin
        failures++;
        $display("FAIL %s okay: ready=%b resp=%b rdata=%h, want ready=1 resp=0 rdata=%h",
                 nm, HREADYOUT, HRESP, HRDATA, exp_rd);
      end
      if (p_val && !p_w) last_rd = HRDATA;
    end
    HSEL = sel; HTRANS = tr; HADDR = a; HWRITE = w; HSIZE = sz; HWDATA = p_wd;
    @(posedge HCLK);
    if (p_val && !p_ill && p_w) begin
      for (int i = 0; i < (1 << p_sz); i++) begin
        ba = int'((p_a + 32'(i)) % NBYTES);
        mb[ba] = p_wd[8*(ba%4) +: 8];
      end
    end
    p_val = sel && tr[1];
    p_ill = illegal(a, sz);
    p_w = w; p_a = a; p_sz = sz; p_wd = wd;
    #1;
  endtask

  task automatic wr(input string nm, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    cyc(nm, 1'b1, 2'b10, a, 1'b1, sz, d);
  endtask

  task automatic rd(input string nm, input logic [31:0] a);
    cyc(nm, 1'b1, 2'b10, a, 1'b0, 3'd2, 32'h0);
  endtask

  task automatic idle(input string nm);
    cyc(nm, 1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic test_reset();
    HRESETn = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
    HSIZE = '0; HBURST = '0; HPROT = '0; HWDATA = '0;
    p_val = 1'b0; p_ill = 1'b0; p_w = 1'b0; p_a = '0; p_sz = '0; p_wd = '0;
    #2 HRESETn = 1'b0;
    #20;
    checks++;
    if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", HREADYOUT); end
    checks++;
    if (HRESP !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b want=0", HRESP); end
    checks++;
    if (HRDATA !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", HRDATA); end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    repeat (3) idle("reset_idle");
  endtask

  task automatic test_word_rw();
    wr("word_rw", 32'h10, 3'd2, 32'hDEADBEEF);
    rd("word_rw", 32'h10);
    idle("word_rw");
    checks++;
    if (last_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_rw got=%h want=deadbeef", last_rd); end
  endtask

  task automatic test_byte_lanes();
    wr("lanes", 32'h20, 3'd2, 32'h11223344);
    wr("lanes", 32'h21, 3'd0, 32'h0000AA00);
    wr("lanes", 32'h22, 3'd1, 32'hBBCC0000);
    rd("lanes", 32'h20);
    idle("lanes");
    checks++;
    if (last_rd !== 32'hBBCCAA44) begin failures++; $display("FAIL lanes got=%h want=bbccaa44", last_rd); end
  endtask

  task automatic test_wrap();
    wr("wrap", 32'h400, 3'd2, 32'h5A5A5A5A);
    rd("wrap", 32'h000);
    idle("wrap");
    checks++;
    if (last_rd !== 32'h5A5A5A5A) begin failures++; $display("FAIL wrap got=%h want=5a5a5a5a", last_rd); end
  endtask

  task automatic test_errors();
    wr("err", 32'h00, 3'd2, 32'hCAFEF00D);
    wr("err", 32'h04, 3'd2, 32'h0BADBEEF);
    wr("err_mis", 32'h02, 3'd2, 32'hFFFFFFFF);
    rd("err_mis", 32'h00);
    wr("err_sz3", 32'h04, 3'd3, 32'hFFFFFFFF);
    wr("err_half", 32'h05, 3'd1, 32'hFFFFFFFF);
    rd("err_half", 32'h04);
    idle("err");
    checks++;
    if (last_rd !== 32'h0BADBEEF) begin failures++; $display("FAIL err_mem got=%h want=0badbeef", last_rd); end
  endtask

  task automatic test_back_to_back_burst();
    HBURST = 3'b011;
    cyc("burst_wr", 1'b1, 2'b10, 32'h40, 1'b1, 3'd2, 32'hA0A0A0A0);
    cyc("burst_wr", 1'b1, 2'b11, 32'h44, 1'b1, 3'd2, 32'hA1A1A1A1);
    cyc("burst_wr", 1'b1, 2'b01, 32'h48, 1'b1, 3'd2, 32'h0);
    cyc("burst_wr", 1'b1, 2'b11, 32'h48, 1'b1, 3'd2, 32'hA2A2A2A2);
    cyc("burst_wr", 1'b1, 2'b11, 32'h4C, 1'b1, 3'd2, 32'hA3A3A3A3);
    cyc("burst_rd", 1'b1, 2'b10, 32'h40, 1'b0, 3'd2, 32'h0);
    cyc("burst_rd", 1'b1, 2'b11, 32'h44, 1'b0, 3'd2, 32'h0);
    cyc("burst_rd", 1'b1, 2'b01, 32'h48, 1'b0, 3'd2, 32'h0);
    cyc("burst_rd", 1'b1, 2'b11, 32'h48, 1'b0, 3'd2, 32'h0);
    cyc("burst_rd", 1'b1, 2'b11, 32'h4C, 1'b0, 3'd2, 32'h0);
    HBURST = 3'b000;
    idle("burst_rd");
    checks++;
    if (last_rd !== 32'hA3A3A3A3) begin failures++; $display("FAIL burst_last got=%h want=a3a3a3a3", last_rd); end
  endtask

  task automatic test_reset_abort();
    wr("abort", 32'h80, 3'd2, 32'h11111111);
    idle("abort");
    wr("abort", 32'h80, 3'd2, 32'h22222222);
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
    p_val = 1'b0;
    #19 HRESETn = 1'b1;
    rd("abort", 32'h80);
    idle("abort");
    checks++;
    if (last_rd !== 32'h11111111) begin failures++; $display("FAIL abort_write got=%h want=11111111", last_rd); end
    wr("abort_err", 32'h00, 3'd3, 32'h0);
    HSEL = 1'b0; HTRANS = 2'b00;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      failures++;
      $display("FAIL abort_err ready=%b resp=%b want ready=1 resp=0", HREADYOUT, HRESP);
    end
    p_val = 1'b0;
    #18 HRESETn = 1'b1;
    idle("abort_err");
  endtask

  task automatic test_random();
    logic        sel, w;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    int          r, off;
    for (int i = 0; i < 16; i++) wr("rnd_init", 32'(i * 4), 3'd2, $urandom);
    for (int k = 0; k < 300; k++) begin
      sel = ($urandom_range(0, 7) != 0);
      tr  = 2'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 9);
      if (r < 3)      begin sz = 3'd0; off = $urandom_range(0, 3); end
      else if (r < 6) begin sz = 3'd1; off = 2 * $urandom_range(0, 1); end
      else if (r < 9) begin sz = 3'd2; off = 0; end
      else if ($urandom_range(0, 1) == 0) begin sz = 3'd3; off = $urandom_range(0, 3); end
      else begin sz = 3'd2; off = $urandom_range(1, 3); end
      a = (32'($urandom_range(0, 3)) << 10) | 32'($urandom_range(0, 15) * 4 + off);
      cyc("random", sel, tr, a, w, sz, $urandom);
    end
    idle("random");
    idle("random");
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_wrap();
    test_errors();
    test_back_to_back_burst();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
